// File: rtl/rx_channel.sv
// HDLC receive channel: flag/abort detection, zero removal, byte assembly,
// frame-end and overflow reporting for a serial line sampled once per Clk.
module rx_channel #(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_AbortSignal,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic [1:0] DbgState
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic        rxSync;
  logic [7:0]  shiftReg;
  logic [7:0]  tagLine;
  logic [6:0]  byteShift;
  logic [2:0]  bitCnt;
  logic [2:0]  onesCnt;
  logic [7:0]  byteCnt;

  logic flagHit, abortHit, candidate, stuffed, accept, byteDone;
  logic clearFrame, eofNext, errNext, abortSigNext;

  // shiftReg doubles as the data delay line: the oldest bit leaves from bit 0.
  // tagLine marks which bits in it arrived after the last flag/abort, so
  // flag and abort bits are never handed to the byte assembler.
  assign flagHit   = (shiftReg == 8'h7E);
  assign abortHit  = (shiftReg == 8'hFE);
  assign candidate = tagLine[0] && !flagHit && !abortHit && (state != HUNT) && RxEN;
  assign stuffed   = candidate && !shiftReg[0] && (onesCnt == 3'd5);
  assign accept    = candidate && !stuffed;
  assign byteDone  = accept && (bitCnt == 3'd7);

  assign Rx_ValidFrame = (state != HUNT);
  assign DbgState      = state;

  always_comb begin
    stateNext    = state;
    clearFrame   = 1'b0;
    eofNext      = 1'b0;
    errNext      = 1'b0;
    abortSigNext = 1'b0;
    if (!RxEN) begin
      stateNext  = HUNT;
      clearFrame = 1'b1;
    end else begin
      case (state)
        HUNT: begin
          clearFrame = 1'b1;
          if (flagHit) stateNext = START;
        end
        START: begin
          if (Rx_AbortDetect) begin
            stateNext    = HUNT;
            abortSigNext = 1'b1;
            clearFrame   = 1'b1;
          end else if (flagHit) begin
            clearFrame = 1'b1;
          end else if (accept) begin
            stateNext = DATA;
          end
        end
        DATA: begin
          if (Rx_AbortDetect) begin
            stateNext    = HUNT;
            abortSigNext = 1'b1;
            clearFrame   = 1'b1;
          end else if (flagHit) begin
            // Closing flag also opens the next frame.
            stateNext  = START;
            eofNext    = 1'b1;
            errNext    = (bitCnt != 3'd0);
            clearFrame = 1'b1;
          end
        end
        default: begin
          stateNext  = HUNT;
          clearFrame = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= HUNT;
      rxSync         <= 1'b1;
      shiftReg       <= 8'hFF;
      tagLine        <= 8'h00;
      byteShift      <= 7'h7F;
      bitCnt         <= 3'd0;
      onesCnt        <= 3'd0;
      byteCnt        <= 8'd0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_Data        <= 8'h00;
      Rx_NewByte     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
    end else begin
      state          <= stateNext;
      rxSync         <= Rx;
      shiftReg       <= {rxSync, shiftReg[7:1]};
      tagLine        <= (flagHit || abortHit) ? 8'h80 : {1'b1, tagLine[7:1]};
      Rx_FlagDetect  <= flagHit;
      Rx_AbortDetect <= abortHit;
      Rx_EoF         <= eofNext;
      Rx_FrameError  <= errNext;
      Rx_AbortSignal <= abortSigNext;
      Rx_NewByte     <= 1'b0;

      if (clearFrame) begin
        bitCnt  <= 3'd0;
        byteCnt <= 8'd0;
        onesCnt <= 3'd0;
      end else if (candidate) begin
        if (shiftReg[0]) begin
          if (onesCnt != 3'd5) onesCnt <= onesCnt + 3'd1;
        end else begin
          onesCnt <= 3'd0;
        end
        if (accept) begin
          byteShift <= {shiftReg[0], byteShift[6:1]};
          bitCnt    <= bitCnt + 3'd1;
          if (byteDone) begin
            if (Rx_Overflow || (byteCnt >= 8'(MAX_BYTES))) begin
              Rx_Overflow <= 1'b1;
            end else begin
              Rx_Data    <= {shiftReg[0], byteShift};
              Rx_NewByte <= 1'b1;
              byteCnt    <= byteCnt + 8'd1;
            end
          end
        end
      end

      if (flagHit || abortHit) Rx_Overflow <= 1'b0;
    end
  end

endmodule
